// File: rtl/udp_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : udp_frame_reader
// Description : Collects one UDP payload (byte stream, IN_BYTES bytes per beat)
//               into a CAPACITY-byte staging buffer and publishes complete
//               frames atomically to o_data with a one-cycle o_valid pulse.
//               Oversize frames are dropped (o_err_ovf). Short frames are
//               flagged with o_err_short and are either discarded or published
//               zero-padded, depending on PAD_SHORT.
// Ports       : clk, rst (async, active-high)
//               i_valid/i_data/i_keep/i_last : input beat stream, no backpressure
//               o_data/o_len                 : last published frame and its length
//               o_valid/o_err_ovf/o_err_short: one-cycle event pulses
//               o_busy                       : frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module udp_frame_reader #(
  parameter int CAPACITY   = 4,
  parameter int IN_BYTES   = 1,
  parameter int BIG_ENDIAN = 1,
  parameter int PAD_SHORT  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [IN_BYTES*8-1:0]         i_data,
  input  logic [IN_BYTES-1:0]           i_keep,
  input  logic                          i_last,
  output logic [CAPACITY*8-1:0]         o_data,
  output logic [$clog2(CAPACITY+1)-1:0] o_len,
  output logic                          o_valid,
  output logic                          o_err_ovf,
  output logic                          o_err_short,
  output logic                          o_busy
);

  localparam int c_CNT_W = $clog2(CAPACITY + 1);
  // Wide enough for cnt + n at its maximum, so the overflow compare never wraps.
  localparam int c_SUM_W = $clog2(CAPACITY + IN_BYTES + 1);
  localparam int c_N_W   = $clog2(IN_BYTES + 1);
  localparam logic [c_SUM_W-1:0] c_CAP_S = c_SUM_W'(CAPACITY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [c_CNT_W-1:0]        cnt_q, cnt_d;
  logic [CAPACITY*8-1:0]     stage_q, stage_d;
  logic [CAPACITY*8-1:0]     data_q, data_d;
  logic [c_CNT_W-1:0]        len_q, len_d;
  logic                      valid_q, valid_d;
  logic                      ovf_q, ovf_d;
  logic                      short_q, short_d;

  logic [c_N_W-1:0]          w_n_keep;
  logic [c_N_W-1:0]          w_n;
  logic [c_CNT_W-1:0]        w_base;
  logic [CAPACITY*8-1:0]     w_stage_base;
  logic [c_SUM_W-1:0]        w_sum;
  logic                      w_fits;
  logic [CAPACITY*8-1:0]     w_merged;

  // Output slot for the b-th byte of the frame.
  function automatic int slot(input int b);
    return (BIG_ENDIAN != 0) ? (CAPACITY - 1 - b) : b;
  endfunction

  // Bytes carried by this beat: full beat unless it is the last one.
  always_comb begin
    w_n_keep = '0;
    for (int k = 0; k < IN_BYTES; k++) begin
      w_n_keep = w_n_keep + c_N_W'(i_keep[k]);
    end
    w_n = i_last ? w_n_keep : c_N_W'(IN_BYTES);
  end

  // A beat seen in IDLE starts a new frame: offset 0 on a cleared buffer.
  assign w_base       = (state_q == S_IDLE) ? '0 : cnt_q;
  assign w_stage_base = (state_q == S_IDLE) ? '0 : stage_q;
  assign w_sum        = c_SUM_W'(w_base) + c_SUM_W'(w_n);
  assign w_fits       = (w_sum <= c_CAP_S);

  // Staging buffer with the current beat merged at offset w_base.
  always_comb begin
    w_merged = w_stage_base;
    for (int b = 0; b < CAPACITY; b++) begin
      for (int k = 0; k < IN_BYTES; k++) begin
        if ((c_N_W'(k) < w_n) &&
            ((c_SUM_W'(w_base) + c_SUM_W'(k)) == c_SUM_W'(b))) begin
          w_merged[slot(b)*8 +: 8] = i_data[k*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    data_d  = data_q;
    len_d   = len_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    short_d = 1'b0;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (i_valid) begin
          if (!w_fits) begin
            if (i_last) begin
              ovf_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DROP;
            end
          end else if (i_last) begin
            state_d = S_IDLE;
            if (w_sum == c_CAP_S) begin
              data_d  = w_merged;
              len_d   = w_sum[c_CNT_W-1:0];
              valid_d = 1'b1;
            end else begin
              short_d = 1'b1;
              if (PAD_SHORT != 0) begin
                // Unwritten bytes are zero because the buffer starts cleared.
                data_d  = w_merged;
                len_d   = w_sum[c_CNT_W-1:0];
                valid_d = 1'b1;
              end
            end
          end else begin
            stage_d = w_merged;
            cnt_d   = w_sum[c_CNT_W-1:0];
            state_d = S_FILL;
          end
        end
      end
      S_DROP: begin
        if (i_valid && i_last) begin
          ovf_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      data_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      short_q <= short_d;
    end
  end

  assign o_data      = data_q;
  assign o_len       = len_q;
  assign o_valid     = valid_q;
  assign o_err_ovf   = ovf_q;
  assign o_err_short = short_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
